// File: rtl/amber48_pkg.sv
// Shared types and constants for the amber48 UART serial path.
package amber48_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_tx_state_e;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DROP_W     = 16;

endpackage

// File: rtl/amber48_sync_fifo.sv
// Single-clock show-ahead FIFO with an explicit level counter so full and
// empty are unambiguous when the pointers coincide.
module amber48_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("amber48_sync_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    // A push into a full FIFO is legal when a pop frees the head slot on the same edge.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/amber48_uart_tx.sv
// 8N1 UART transmitter fed by a no-backpressure byte strobe; bytes that
// arrive while the FIFO is full are dropped and counted.
module amber48_uart_tx
    import amber48_pkg::*;
#(
    parameter int CLK_HZ     = 27_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tx_valid_i,
    input  logic [7:0]             tx_data_i,
    input  logic                   clr_overflow_i,
    output logic                   txd_o,
    output logic                   busy_o,
    output logic [LVL_W-1:0]       fifo_level_o,
    output logic                   overflow_o,
    output logic [UART_DROP_W-1:0] drop_count_o
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_FRAME_BITS - 3);

    if (DIV < 2) begin : g_div_chk
        $error("amber48_uart_tx: CLK_HZ/BAUD divisor must be >= 2");
    end

    function automatic logic [UART_DROP_W-1:0] sat_inc(input logic [UART_DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    uart_tx_state_e         state_q, state_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic                   ovf_q, ovf_d;
    logic [UART_DROP_W-1:0] drop_q, drop_d;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [7:0]             fifo_rdata;
    logic [LVL_W-1:0]       fifo_level;
    logic                   tmr_zero;

    amber48_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (tx_data_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign tmr_zero  = (tmr_q == '0);
    assign fifo_push = tx_valid_i && (!fifo_full || fifo_pop);
    assign drop      = tx_valid_i && fifo_full && !fifo_pop;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        case (state_q)
            UART_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    tmr_d    = TMR_LOAD;
                    state_d  = UART_START;
                    txd_d    = 1'b0;
                end
            end
            UART_START: begin
                if (tmr_zero) begin
                    state_d = UART_DATA;
                    bit_d   = '0;
                    tmr_d   = TMR_LOAD;
                    txd_d   = shift_q[0];
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            UART_DATA: begin
                if (tmr_zero) begin
                    tmr_d = TMR_LOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = UART_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            UART_STOP: begin
                if (tmr_zero) begin
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tmr_d    = TMR_LOAD;
                        state_d  = UART_START;
                        txd_d    = 1'b0;
                    end else begin
                        state_d = UART_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = UART_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // A drop landing on the same edge as a clear survives as a single count.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr_overflow_i) begin
            ovf_d  = drop;
            drop_d = drop ? UART_DROP_W'(1) : '0;
        end else if (drop) begin
            ovf_d  = 1'b1;
            drop_d = sat_inc(drop_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= UART_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

    assign txd_o        = txd_q;
    assign busy_o       = (state_q != UART_IDLE) || (fifo_level != '0);
    assign fifo_level_o = fifo_level;
    assign overflow_o   = ovf_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_amber48_uart_tx.sv
// Directed bench for amber48_uart_tx at DIV=4 with a 4-entry FIFO.
module tb_amber48_uart_tx;

    localparam int CLK_HZ     = 1_000_000;
    localparam int BAUD       = 250_000;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             clr_ovf;
    logic             txd;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic             ovf;
    logic [15:0]      drops;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic [0:9] frame;
    } vec_t;

    vec_t vec [12];

    amber48_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tx_valid_i     (tx_valid),
        .tx_data_i      (tx_data),
        .clr_overflow_i (clr_ovf),
        .txd_o          (txd),
        .busy_o         (busy),
        .fifo_level_o   (level),
        .overflow_o     (ovf),
        .drop_count_o   (drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Entered right after the edge that starts the start bit; leaves right
    // after the edge 40 cycles later (next start bit or idle).
    task automatic check_frame(input string nm, input logic [0:9] fr);
        for (int i = 0; i < 40; i++) begin
            chk(nm, 32'(txd), 32'(fr[i / 4]));
            tick();
        end
    endtask

    task automatic strobe(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_single(input int idx);
        strobe(vec[idx].data);
        chk("lat_txd_high", 32'(txd), 32'd1);
        chk("lat_level1", 32'(level), 32'd1);
        chk("lat_busy", 32'(busy), 32'd1);
        tick();
        chk("start_level0", 32'(level), 32'd0);
        check_frame($sformatf("frame_%02h", vec[idx].data), vec[idx].frame);
        chk("end_busy0", 32'(busy), 32'd0);
        chk("end_txd1", 32'(txd), 32'd1);
    endtask

    initial begin
        vec[0]  = '{8'hA5, 10'b0101001011};
        vec[1]  = '{8'h55, 10'b0101010101};
        vec[2]  = '{8'h0F, 10'b0111100001};
        vec[3]  = '{8'h01, 10'b0100000001};
        vec[4]  = '{8'h02, 10'b0010000001};
        vec[5]  = '{8'h03, 10'b0110000001};
        vec[6]  = '{8'h04, 10'b0001000001};
        vec[7]  = '{8'h07, 10'b0111000001};
        vec[8]  = '{8'h81, 10'b0100000011};
        vec[9]  = '{8'h00, 10'b0000000001};
        vec[10] = '{8'hFF, 10'b0111111111};
        vec[11] = '{8'h3C, 10'b0001111001};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        clr_ovf  = 1'b0;
        tick_n(2);
        rst = 1'b0;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_drops", 32'(drops), 32'd0);

        // Single bytes from idle, table-driven.
        for (int v = 0; v < 12; v++) begin
            send_single(v);
            tick_n(2);
        end

        // Back-to-back strobes: the second push coincides with the first pop.
        strobe(8'h55);
        tx_valid = 1'b1;
        tx_data  = 8'h0F;
        chk("b2b_level_a", 32'(level), 32'd1);
        tick();
        tx_valid = 1'b0;
        chk("b2b_level_b", 32'(level), 32'd1);
        check_frame("b2b_55", vec[1].frame);
        chk("b2b_level_c", 32'(level), 32'd0);
        check_frame("b2b_0F", vec[2].frame);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Overflow: six strobes while a frame is in progress.
        strobe(8'hA5);
        tick();
        for (int k = 0; k < 6; k++) begin
            strobe(8'(k + 1));
            chk("ovf_level", 32'(level), 32'((k + 1 < 4) ? k + 1 : 4));
        end
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_drops2", 32'(drops), 32'd2);
        tick_n(34);
        check_frame("ovf_01", vec[3].frame);
        check_frame("ovf_02", vec[4].frame);
        check_frame("ovf_03", vec[5].frame);
        check_frame("ovf_04", vec[6].frame);
        chk("ovf_idle_busy", 32'(busy), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // Clear colliding with a drop.
        strobe(8'hA5);
        for (int k = 1; k <= 5; k++) strobe(8'(k));
        chk("clr_pre_drops3", 32'(drops), 32'd3);
        chk("clr_pre_level4", 32'(level), 32'd4);
        clr_ovf = 1'b1;
        strobe(8'h06);
        chk("clr_col_ovf", 32'(ovf), 32'd1);
        chk("clr_col_drops", 32'(drops), 32'd1);
        tick();
        clr_ovf = 1'b0;
        chk("clr_only_ovf", 32'(ovf), 32'd0);
        chk("clr_only_drops", 32'(drops), 32'd0);

        // Push into a full FIFO on the edge where STOP pops.
        tick_n(33);
        chk("pp_pre_level", 32'(level), 32'd4);
        chk("pp_pre_stop", 32'(txd), 32'd1);
        strobe(8'h07);
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_nodrop", 32'(drops), 32'd0);
        chk("pp_noovf", 32'(ovf), 32'd0);
        check_frame("pp_01", vec[3].frame);
        check_frame("pp_02", vec[4].frame);
        check_frame("pp_03", vec[5].frame);
        check_frame("pp_04", vec[6].frame);
        check_frame("pp_07", vec[7].frame);
        chk("pp_idle", 32'(busy), 32'd0);

        // Reset during data bit 3 with three bytes queued.
        strobe(8'hA5);
        for (int k = 1; k <= 3; k++) strobe(8'(k));
        tick_n(15);
        chk("mid_level3", 32'(level), 32'd3);
        chk("mid_bit3", 32'(txd), 32'(vec[0].frame[4]));
        do_reset();
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick_n(5);
        chk("mid_rst_quiet", 32'(txd), 32'd1);
        send_single(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
